fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Purpose : instruction fetch front-end; one outstanding imem request, DEPTH-entry queue to decode.
// Latency : request handshake -> dec_valid = memory latency + 1 cycle (registered queue write).
// Backpr. : no request while the queue is full or a request is in flight; decode stalls via dec_ready.
//
// Ports
//   clk, rst            : single clock, synchronous active-low reset
//   pc / pc_en_n        : fetch address from the PC register; active-low advance strobe back to it
//   flush               : redirect, drops queued and in-flight instructions
//   imem_req_*          : request channel (valid/ready, address = pc)
//   imem_rsp_*          : response channel (valid only, no backpressure)
//   dec_*               : queue head to decode (valid/ready, instruction + its address)
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.

module fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en_n,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_REQ   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [31:0]   r_pend_pc;

    // Queue storage; contents are qualified by r_count, so no reset.
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic          w_full;
    logic          w_req_vld;
    logic          w_req_hs;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_count_nxt;

    assign w_full    = (r_count == CW'(DEPTH));

    // Everything observable is gated with rst so the reset cycle is quiet
    // regardless of what the other inputs are doing.
    assign w_req_vld = rst && (r_state == ST_REQ) && !w_full && !flush;
    assign w_req_hs  = w_req_vld && imem_req_ready;

    // Only a WAIT-state response is ever accepted; stray responses in REQ
    // are ignored and the one owed in DRAIN is dropped.
    assign w_push    = rst && (r_state == ST_WAIT) && imem_rsp_valid && !flush;
    assign w_pop     = dec_valid && dec_ready && !flush;

    assign imem_req_valid = w_req_vld;
    assign imem_req_addr  = pc;

    // PC advances once per accepted request, and also on flush so the
    // PC register can load its redirect target.
    assign pc_en_n   = rst ? !(w_req_hs || flush) : 1'b1;

    assign dec_valid = rst && (r_count != '0);
    assign dec_instr = r_q_instr[r_rptr];
    assign dec_pc    = r_q_pc[r_rptr];

    // Next FSM state. Flush overrides everything: a WAIT with no response
    // this cycle must still swallow the late response, hence DRAIN; if the
    // response lands in the flush cycle itself it is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            if (r_state == ST_WAIT && !imem_rsp_valid) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_REQ;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_req_hs) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_REQ;
                end
            endcase
        end
    end

    // Occupancy; a push can only happen with count < DEPTH because the
    // request that produced it needed room and nothing is pushed in between.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Abandons any outstanding request outright; no drain.
            r_state   <= ST_REQ;
            r_count   <= '0;
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_pend_pc <= '0;
        end else if (flush) begin
            r_state   <= w_state_nxt;
            r_count   <= '0;
            r_rptr    <= '0;
            r_wptr    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            if (w_req_hs) begin
                r_pend_pc <= pc;
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wptr] <= imem_rsp_data;
            r_q_pc[r_wptr]    <= r_pend_pc;
        end
    end

endmodule
